bcd_disp_scan: RTL and testbench

//  Downstream stage of the 2-digit BCD adder. Captures a 3-digit BCD result on a load strobe:

---
 rtl/bcd_disp_scan.sv | 149 ++++++++++++++
 tb/tb_bcd_disp_scan.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_disp_scan.sv
// bcd_disp_scan: captures a 3-digit BCD result and scans it onto a
// multiplexed 7-segment display. Optional macro LZB_EN: leading-zero blanking.
module bcd_disp_scan #(
    parameter int PRESCALE      = 4,
    parameter bit AN_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic       d2,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       err,
    output logic       frame
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [2:0] AN_OFF = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2
    } slot_e;

    slot_e         idx_q, idx_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          run_q, run_d;
    logic [3:0]    h0_q, h0_d;
    logic [3:0]    h1_q, h1_d;
    logic          h2_q, h2_d;
    logic          err_q, err_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          frame_q, frame_d;
    logic          slot_end;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Next-state: prescaler, scan slot, hold registers and output image.
    // The first edge after reset only arms the scan (run_q) so that the
    // first visible slot shows an=001 for a full PRESCALE cycles.
    always_comb begin
        pcnt_d   = pcnt_q;
        idx_d    = idx_q;
        run_d    = 1'b1;
        h0_d     = h0_q;
        h1_d     = h1_q;
        h2_d     = h2_q;
        err_d    = err_q;
        seg_d    = 7'h00;
        an_d     = AN_OFF;
        frame_d  = 1'b0;
        slot_end = run_q && (pcnt_q == PLAST);

        if (run_q) begin
            pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;
        end

        if (slot_end) begin
            unique case (idx_q)
                SLOT0:   idx_d = SLOT1;
                SLOT1:   idx_d = SLOT2;
                default: idx_d = SLOT0;
            endcase
            frame_d = (idx_q == SLOT2);
        end

        if (load) begin
            h0_d  = d0;
            h1_d  = d1;
            h2_d  = d2;
            err_d = (d0 > 4'd9) || (d1 > 4'd9);
        end

        unique case (idx_d)
            SLOT0: begin
                an_d  = 3'b001 ^ AN_OFF;
                seg_d = dec7(h0_d);
            end
            SLOT1: begin
                an_d  = 3'b010 ^ AN_OFF;
                seg_d = dec7(h1_d);
`ifdef LZB_EN
                if (!h2_d && (h1_d == 4'd0)) seg_d = 7'h00;
`endif
            end
            default: begin
                an_d  = 3'b100 ^ AN_OFF;
                seg_d = dec7({3'b000, h2_d});
`ifdef LZB_EN
                if (!h2_d) seg_d = 7'h00;
`endif
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q  <= '0;
            idx_q   <= SLOT0;
            run_q   <= 1'b0;
            h0_q    <= 4'd0;
            h1_q    <= 4'd0;
            h2_q    <= 1'b0;
            err_q   <= 1'b0;
            seg_q   <= 7'h00;
            an_q    <= AN_OFF;
            frame_q <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            err_q   <= err_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign err   = err_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// tb_bcd_disp_scan: directed bench with a cycle-count model of the scan
// and hold registers, checked every cycle, plus literal spot checks.
module tb_bcd_disp_scan;

    localparam int P = 4;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       d2;
    logic [6:0] seg;
    logic [2:0] an;
    logic       err;
    logic       frame;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_disp_scan #(.PRESCALE(P), .AN_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .load(load),
        .d0(d0), .d1(d1), .d2(d2),
        .seg(seg), .an(an), .err(err), .frame(frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                                7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Model: mk = non-reset edges since the last reset edge.
    int         mk = 0;
    bit         mvalid = 1'b0;
    logic [3:0] m0, m1;
    logic       m2, merr;

    always @(posedge clk) begin
        if (rst) begin
            mk     <= 0;
            m0     <= 4'd0;
            m1     <= 4'd0;
            m2     <= 1'b0;
            merr   <= 1'b0;
            mvalid <= 1'b1;
        end else begin
            mk <= mk + 1;
            if (load) begin
                m0   <= d0;
                m1   <= d1;
                m2   <= d2;
                merr <= (d0 > 9) || (d1 > 9);
            end
        end
    end

    function automatic logic [6:0] mseg(input int slot);
        if (slot == 0) return segtab[m0];
        if (slot == 1) return (LZB && !m2 && m1 == 0) ? 7'h00 : segtab[m1];
        if (LZB && !m2) return 7'h00;
        return m2 ? 7'h06 : 7'h3F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            int   slot;
            logic [2:0] ean;
            logic [6:0] eseg;
            logic       efr;
            if (mk == 0) begin
                ean  = 3'b000;
                eseg = 7'h00;
                efr  = 1'b0;
            end else begin
                slot = ((mk - 1) / P) % 3;
                ean  = 3'(1 << slot);
                eseg = mseg(slot);
                efr  = (mk > 1) && ((mk - 1) % (3 * P) == 0);
            end
            chk("model_an", an, ean);
            chk("model_seg", seg, eseg);
            chk("model_err", err, merr);
            chk("model_frame", frame, efr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [2:0] v);
        for (int i = 0; i < 40 && an !== v; i++) tick();
        chk("wait_an", an, v);
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 40 && frame !== 1'b1; i++) tick();
        chk("wait_frame", frame, 1'b1);
    endtask

    task automatic do_load(input logic [3:0] a0, input logic [3:0] a1,
                           input logic a2);
        load = 1'b1;
        d0   = a0;
        d1   = a1;
        d2   = a2;
        tick();
        load = 1'b0;
    endtask

    task automatic count_slot0(input int start, output int cnt);
        cnt = start;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (an === 3'b001) cnt++;
            else break;
        end
    endtask

    initial begin
        int nfr;
        int cnt;
        rst  = 1'b1;
        load = 1'b0;
        d0   = 4'd0;
        d1   = 4'd0;
        d2   = 1'b0;
        repeat (3) tick();
        chk("rst_seg", seg, 7'h00);
        chk("rst_an", an, 3'b000);
        chk("rst_err", err, 1'b0);
        chk("rst_frame", frame, 1'b0);
        rst = 1'b0;
        tick();
        chk("rel_an", an, 3'b001);
        chk("rel_seg", seg, 7'h3F);
        chk("rel_frame", frame, 1'b0);
        count_slot0(1, cnt);
        chk("first_slot_len", cnt, P);

        do_load(4'd7, 4'd4, 1'b1);
        wait_an(3'b001);
        chk("d147_u", seg, 7'h07);
        wait_an(3'b010);
        chk("d147_t", seg, 7'h66);
        wait_an(3'b100);
        chk("d147_h", seg, 7'h06);
        nfr = 0;
        for (int i = 0; i < 6 * P; i++) begin
            tick();
            if (frame === 1'b1) nfr++;
        end
        chk("frame_cnt", nfr, 2);

        do_load(4'd5, 4'd0, 1'b0);
        wait_an(3'b001);
        chk("d005_u", seg, 7'h6D);
        wait_an(3'b010);
        chk("d005_t", seg, LZB ? 7'h00 : 7'h3F);
        wait_an(3'b100);
        chk("d005_h", seg, LZB ? 7'h00 : 7'h3F);

        do_load(4'd12, 4'd3, 1'b0);
        chk("err_set", err, 1'b1);
        wait_an(3'b001);
        chk("dash", seg, 7'h40);
        do_load(4'd2, 4'd3, 1'b0);
        chk("err_clr", err, 1'b0);
        wait_an(3'b001);
        chk("d2_u", seg, 7'h5B);

        wait_frame();
        tick();
        do_load(4'd8, 4'd3, 1'b0);
        chk("mid_load_seg", seg, 7'h7F);
        chk("mid_load_an", an, 3'b001);
        count_slot0(3, cnt);
        chk("no_restart", cnt, P);

        wait_an(3'b010);
        wait_an(3'b100);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_an", an, 3'b000);
        chk("mid_rst_seg", seg, 7'h00);
        tick();
        chk("post_rst_an", an, 3'b001);
        chk("post_rst_seg", seg, 7'h3F);
        chk("post_rst_frame", frame, 1'b0);
        count_slot0(1, cnt);
        chk("fresh_slot", cnt, P);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
